lcd_window_timing: RTL and testbench

LCD_WINDOW_TIMING -- requirements
Module: lcd_window_timing

---
 rtl/lcd_window_timing.sv | 186 ++++++++++++++++++
 tb/tb_lcd_window_timing.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_window_timing.sv
// lcd_window_timing
//   Generates parallel-RGB LCD timing and places a scaled video-memory
//   window inside the visible area. Pixels outside the window show a
//   diagonal (x+y) test gradient. The memory read latency is absorbed by
//   delay lines, so syncs, data enable, frame marker and colour stay
//   aligned. The total delay from counter state to outputs is RAM_LAT+2
//   clocks.
//
// Ports
//   clk          pixel clock (the only clock)
//   rst          asynchronous reset, active low
//   en           scan enable; while low the counters park at (0,0)
//   ram_addr     registered memory read address {row, col}
//   ram_data     memory read data, valid RAM_LAT clocks after ram_addr
//   frame_start  one-cycle pulse on the first output cycle of a frame
//   lcd_hsync    horizontal sync, active low
//   lcd_vsync    vertical sync, active low
//   lcd_den      data enable, active high
//   lcd_r/g/b    5/6/5-bit colour
module lcd_window_timing #(
  parameter int H_ACTIVE   = 480,
  parameter int H_BP       = 43,
  parameter int H_FP       = 8,
  parameter int H_PULSE    = 4,
  parameter int V_ACTIVE   = 272,
  parameter int V_BP       = 12,
  parameter int V_FP       = 8,
  parameter int V_PULSE    = 4,
  parameter int WIN_X      = 160,
  parameter int WIN_Y      = 8,
  parameter int WIN_LOG2   = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int RAM_LAT    = 1,
  localparam int AW        = 2 * (WIN_LOG2 - SCALE_LOG2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] ram_addr,
  input  logic [8:0]    ram_data,
  output logic          frame_start,
  output logic          lcd_hsync,
  output logic          lcd_vsync,
  output logic          lcd_den,
  output logic [4:0]    lcd_r,
  output logic [5:0]    lcd_g,
  output logic [4:0]    lcd_b
);

  localparam int H_TOTAL  = H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL  = V_BP + V_ACTIVE + V_FP;
  localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int FW       = WIN_LOG2 - SCALE_LOG2;
  localparam int WIN_SIZE = 1 << WIN_LOG2;
  // Stages between the counters and the output register; the memory
  // path spends one of them in the ram_addr register and RAM_LAT in
  // the memory itself.
  localparam int ND       = RAM_LAT + 1;

  // Syncs travel as active-high pulses so that an all-zero (reset)
  // stage means "idle" and the pipeline never emits a spurious sync.
  // Only pixel bits [8:3] are carried since the colour fields use no
  // lower bits.
  typedef struct packed {
    logic       hs_act;
    logic       vs_act;
    logic       den;
    logic       in_win;
    logic       fs;
    logic [5:0] pix;
  } stage_t;

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  int            x, y;
  logic          visible, in_win;
  logic [FW-1:0] row, col;
  stage_t        raw;
  stage_t        pipe_q [ND];
  stage_t        last;
  logic [5:0]    pix_out;
  logic          lcd_hsync_q, lcd_vsync_q, lcd_den_q, frame_start_q;
  logic [4:0]    lcd_r_q, lcd_b_q;
  logic [5:0]    lcd_g_q;
  logic          unused_ram_lsbs;

  // Raster counters: park at (0,0) while disabled so that raising en
  // always begins a complete frame.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!en) begin
      hc_d = '0;
      vc_d = '0;
    end else if (int'(hc_q) == H_TOTAL - 1) begin
      hc_d = '0;
      vc_d = (int'(vc_q) == V_TOTAL - 1) ? '0 : vc_q + 1'b1;
    end else begin
      hc_d = hc_q + 1'b1;
    end
  end

  // Raw timing decode and window address from the current counter state.
  always_comb begin
    x       = int'(hc_q) - H_BP;
    y       = int'(vc_q) - V_BP;
    visible = en && (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
    in_win  = visible && (x >= WIN_X) && (x < WIN_X + WIN_SIZE)
                      && (y >= WIN_Y) && (y < WIN_Y + WIN_SIZE);
    col     = FW'((x - WIN_X) >> SCALE_LOG2);
    row     = FW'((y - WIN_Y) >> SCALE_LOG2);
    raw        = '0;
    raw.hs_act = en && (int'(hc_q) < H_PULSE);
    raw.vs_act = en && (int'(vc_q) < V_PULSE);
    raw.den    = visible;
    raw.in_win = in_win;
    raw.fs     = en && (hc_q == '0) && (vc_q == '0);
    // (x+y) mod 512 keeps bits [8:3] as ((x+y)>>3) mod 64.
    raw.pix    = visible ? 6'((x + y) >> 3) : 6'd0;
    ram_addr_d = in_win ? {row, col} : ram_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q       <= '0;
      vc_q       <= '0;
      ram_addr_q <= '0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  // Delay line that keeps control and fallback pixel level with the
  // memory read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ND; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i < ND; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    last    = pipe_q[ND-1];
    pix_out = last.in_win ? ram_data[8:3] : last.pix;
  end

  // The low data bits never reach the 5/6/5 colour fields.
  assign unused_ram_lsbs = ^ram_data[2:0];

  // Final output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_hsync_q   <= 1'b1;
      lcd_vsync_q   <= 1'b1;
      lcd_den_q     <= 1'b0;
      frame_start_q <= 1'b0;
      lcd_r_q       <= '0;
      lcd_g_q       <= '0;
      lcd_b_q       <= '0;
    end else begin
      lcd_hsync_q   <= ~last.hs_act;
      lcd_vsync_q   <= ~last.vs_act;
      lcd_den_q     <= last.den;
      frame_start_q <= last.fs;
      lcd_r_q       <= pix_out[5:1];
      lcd_g_q       <= pix_out;
      lcd_b_q       <= pix_out[5:1];
    end
  end

  assign ram_addr    = ram_addr_q;
  assign frame_start = frame_start_q;
  assign lcd_hsync   = lcd_hsync_q;
  assign lcd_vsync   = lcd_vsync_q;
  assign lcd_den     = lcd_den_q;
  assign lcd_r       = lcd_r_q;
  assign lcd_g       = lcd_g_q;
  assign lcd_b       = lcd_b_q;

endmodule

// File: tb/tb_lcd_window_timing.sv
// tb_lcd_window_timing
//   Self-checking bench for lcd_window_timing on a small raster
//   (33 x 24 clocks, 8x8 window at 2x2 scaling, two-clock memory).
//   A behavioural raster model predicts every output cycle, and a set
//   of hand-worked points pins that model down.
module tb_lcd_window_timing;

  localparam int H_ACTIVE   = 24;
  localparam int H_BP       = 6;
  localparam int H_FP       = 3;
  localparam int H_PULSE    = 2;
  localparam int V_ACTIVE   = 18;
  localparam int V_BP       = 4;
  localparam int V_FP       = 2;
  localparam int V_PULSE    = 1;
  localparam int WIN_X      = 5;
  localparam int WIN_Y      = 3;
  localparam int WIN_LOG2   = 3;
  localparam int SCALE_LOG2 = 1;
  localparam int RAM_LAT    = 2;
  localparam int AW         = 2 * (WIN_LOG2 - SCALE_LOG2);
  localparam int L          = RAM_LAT + 2;
  localparam int H_TOTAL    = H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL    = V_BP + V_ACTIVE + V_FP;
  localparam int WIN        = 1 << WIN_LOG2;
  localparam int SCALE      = 1 << SCALE_LOG2;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       den;
    logic       fs;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } outVec_t;

  localparam outVec_t IDLE = '{hs: 1'b1, vs: 1'b1, den: 1'b0, fs: 1'b0,
                               r: 5'd0, g: 6'd0, b: 5'd0};

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] ram_addr;
  logic [8:0]    ram_data;
  logic          frame_start, lcd_hsync, lcd_vsync, lcd_den;
  logic [4:0]    lcd_r, lcd_b;
  logic [5:0]    lcd_g;

  int tests    = 0;
  int failures = 0;

  lcd_window_timing #(
    .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_FP(H_FP), .H_PULSE(H_PULSE),
    .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .V_FP(V_FP), .V_PULSE(V_PULSE),
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_LOG2(WIN_LOG2),
    .SCALE_LOG2(SCALE_LOG2), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ram_addr(ram_addr), .ram_data(ram_data),
    .frame_start(frame_start), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_den(lcd_den), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
  );

  always #5 clk = ~clk;

  // Video memory with a RAM_LAT-clock read pipeline.
  logic [8:0] mem [0:(1<<AW)-1];
  logic [8:0] ramPipe [0:RAM_LAT-1];

  always @(posedge clk) begin
    ramPipe[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) ramPipe[i] <= ramPipe[i-1];
  end
  assign ram_data = ramPipe[RAM_LAT-1];

  // What the display must show for a raster position, straight from
  // the timing and window rules.
  function automatic int winAddr(int x, int y);
    return ((y - WIN_Y) / SCALE) * (WIN / SCALE) + (x - WIN_X) / SCALE;
  endfunction

  function automatic bit inWindow(int hc, int vc, bit e);
    int x = hc - H_BP;
    int y = vc - V_BP;
    bit vis = e && x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE;
    return vis && x >= WIN_X && x < WIN_X + WIN && y >= WIN_Y && y < WIN_Y + WIN;
  endfunction

  function automatic outVec_t modelPixel(int hc, int vc, bit e);
    outVec_t o;
    int x = hc - H_BP;
    int y = vc - V_BP;
    int p;
    bit vis = e && x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE;
    if (inWindow(hc, vc, e)) p = int'(mem[winAddr(x, y)]);
    else if (vis)            p = (x + y) % 512;
    else                     p = 0;
    o.hs  = !(e && hc < H_PULSE);
    o.vs  = !(e && vc < V_PULSE);
    o.den = vis;
    o.fs  = e && hc == 0 && vc == 0;
    o.r   = 5'(p / 16);
    o.g   = 6'(p / 8);
    o.b   = 5'(p / 16);
    return o;
  endfunction

  // Model state: raster position, history of L outputs, held address
  // and the count of clocks since reset release.
  int            mhc, mvc, cyc;
  outVec_t       hist[$];
  outVec_t       expOut;
  logic [AW-1:0] expAddr;

  always @(posedge clk) begin
    if (!rst) begin
      hist = {};
      for (int i = 0; i < L - 1; i++) hist.push_back(IDLE);
      expOut  = IDLE;
      expAddr = '0;
      mhc = 0;
      mvc = 0;
      cyc = 0;
    end else begin
      hist.push_back(modelPixel(mhc, mvc, en));
      expOut = hist.pop_front();
      if (inWindow(mhc, mvc, en)) expAddr = AW'(winAddr(mhc - H_BP, mvc - V_BP));
      if (!en) begin
        mhc = 0;
        mvc = 0;
      end else begin
        mhc++;
        if (mhc == H_TOTAL) begin
          mhc = 0;
          mvc++;
          if (mvc == V_TOTAL) mvc = 0;
        end
      end
      cyc++;
    end
  end

  function automatic outVec_t actual();
    outVec_t a;
    a.hs = lcd_hsync; a.vs = lcd_vsync; a.den = lcd_den; a.fs = frame_start;
    a.r = lcd_r; a.g = lcd_g; a.b = lcd_b;
    return a;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    outVec_t       want;
    logic [AW-1:0] wantAddr;
    want     = rst ? expOut : IDLE;
    wantAddr = rst ? expAddr : '0;
    tests++;
    if (actual() !== want || ram_addr !== wantAddr) begin
      failures++;
      $display("[TB] FAIL cycle t=%0t: got out=%h addr=%h, expected out=%h addr=%h",
               $time, actual(), ram_addr, want, wantAddr);
    end
  end

  task automatic checkOutput(string name, outVec_t want);
    tests++;
    if (actual() !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual(), want);
    end
  endtask

  task automatic checkAddr(string name, logic [AW-1:0] want);
    tests++;
    if (ram_addr !== want) begin
      failures++;
      $display("[TB] FAIL %s: got addr %h, expected %h", name, ram_addr, want);
    end
  endtask

  // Advance to the falling edge after clock k since reset release.
  task automatic waitCyc(int k);
    int guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      tests++;
      failures++;
      $display("[TB] FAIL waitCyc: reached cycle %0d, wanted %0d", cyc, k);
    end
  endtask

  // Cycle on which the output for counter state (hc,vc) appears.
  function automatic int outCyc(int hc, int vc);
    return vc * H_TOTAL + hc + L;
  endfunction

  // Measure clocks from now until frame_start; required value is L.
  task automatic checkFrameStartDelay(string name);
    int start = cyc;
    bit found = 0;
    for (int i = 0; i < 3 * L && !found; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1;
    end
    tests++;
    if (!found || cyc - start != L) begin
      failures++;
      $display("[TB] FAIL %s: frame_start delay %0d (found=%0d), expected %0d",
               name, cyc - start, found, L);
    end
  endtask

  task automatic applyStimulus(int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      if (en && $urandom_range(0, 1499) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 9'(511 - i * 32);
    repeat (3) @(negedge clk);
    checkOutput("reset-state", IDLE);
    checkAddr("reset-addr", '0);
    rst = 1'b1;

    // Hand-worked points in the first frame.
    waitCyc(outCyc(0, 0));
    checkOutput("first-frame-start",
                '{hs: 0, vs: 0, den: 0, fs: 1, r: 0, g: 0, b: 0});
    waitCyc(outCyc(26, 5));
    checkOutput("gradient-x20-y1",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 1, g: 2, b: 1});
    waitCyc(outCyc(10, 7));
    checkOutput("left-of-window",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 0, g: 0, b: 0});
    checkAddr("addr-col1", 4'd1);
    waitCyc(outCyc(11, 7));
    checkOutput("window-first-pixel",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 31, g: 63, b: 31});
    waitCyc(14 * H_TOTAL + 18 + 1);
    checkAddr("addr-last", 4'd15);
    waitCyc(outCyc(18, 14));
    checkOutput("window-last-pixel",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 1, g: 3, b: 1});
    waitCyc(outCyc(19, 14));
    checkOutput("right-of-window",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 1, g: 2, b: 1});
    waitCyc(700);
    checkAddr("addr-held", 4'd15);
    waitCyc(outCyc(29, 21));
    checkOutput("last-visible-pixel",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 2, g: 5, b: 2});
    waitCyc(outCyc(30, 21));
    checkOutput("front-porch", IDLE);
    waitCyc(outCyc(1, 22));
    checkOutput("hsync-pulse",
                '{hs: 0, vs: 1, den: 0, fs: 0, r: 0, g: 0, b: 0});
    waitCyc(H_TOTAL * V_TOTAL + L - 1);
    checkOutput("frame-end", IDLE);
    waitCyc(H_TOTAL * V_TOTAL + L);
    checkOutput("second-frame-start",
                '{hs: 0, vs: 0, den: 0, fs: 1, r: 0, g: 0, b: 0});

    // Drop en mid-line (state hc=15 of line 5), then raise it again.
    waitCyc(H_TOTAL * V_TOTAL + 5 * H_TOTAL + 15);
    en = 1'b0;
    waitCyc(H_TOTAL * V_TOTAL + 5 * H_TOTAL + 15 + L - 1);
    checkOutput("drain-before-drop",
                '{hs: 1, vs: 1, den: 1, fs: 0, r: 0, g: 1, b: 0});
    waitCyc(H_TOTAL * V_TOTAL + 5 * H_TOTAL + 15 + L);
    checkOutput("idle-after-drop", IDLE);
    repeat (3) @(negedge clk);
    en = 1'b1;
    checkFrameStartDelay("restart-frame-start");

    // Asynchronous reset between clock edges, new memory contents.
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async-reset", IDLE);
    checkAddr("async-reset-addr", '0);
    for (int i = 0; i < (1 << AW); i++) mem[i] = 9'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checkFrameStartDelay("post-reset-frame-start");

    applyStimulus(6000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
